rca_mp_sequencer: RTL

Multi-precision add/subtract controller that time-multiplexes one 8-bit ripple-carry adder (the existing `RCA8`) across wide operands. It adds or subtracts two `8*WORDS`-bit operands one byte per cycle, least-significant byte first, carrying between bytes through a registered carry. It sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.

---
 rtl/rca_seq_pkg.sv | 12 +
 rtl/RCA8.sv | 21 ++
 rtl/rca_mp_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the multi-precision ripple-carry sequencer.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/RCA8.sv
// 8-bit ripple-carry adder built from a chain of full-adder cells.
module RCA8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    logic [8:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[8];

endmodule

// File: rtl/rca_mp_sequencer.sv
// Wide add/subtract computed one byte per cycle through a single RCA8,
// least-significant byte first, with valid/ready on both sides.
module rca_mp_sequencer
    import rca_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BYTE_W*WORDS-1:0]   a,
    input  logic [BYTE_W*WORDS-1:0]   b,
    input  logic                      cin,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W*WORDS-1:0]   sum,
    output logic                      cout,
    output logic                      ovf,
    output logic                      busy
);

    localparam int W     = BYTE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t             state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       res;
    logic [W-1:0]       res_next;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               last;

    logic [BYTE_W-1:0]  byte_a;
    logic [BYTE_W-1:0]  byte_b;
    logic [BYTE_W-1:0]  byte_s;
    logic               byte_c;

    assign last = (idx == IDX_W'(WORDS - 1));

    // Byte lane selection for the shared adder.
    always_comb begin
        byte_a = '0;
        byte_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                byte_a = a_reg[i*BYTE_W +: BYTE_W];
                byte_b = b_reg[i*BYTE_W +: BYTE_W];
            end
        end
    end

    RCA8 u_rca8 (
        .A    (byte_a),
        .B    (byte_b),
        .Cin  (carry),
        .S    (byte_s),
        .Cout (byte_c)
    );

    // Result with the current adder byte merged in; feeds both res and sum.
    always_comb begin
        res_next = res;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                res_next[i*BYTE_W +: BYTE_W] = byte_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= byte_c;
                    if (last) begin
                        sum       <= res_next;
                        cout      <= byte_c;
                        ovf       <= (a_reg[W-1] == b_reg[W-1]) &&
                                     (byte_s[BYTE_W-1] != a_reg[W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

endmodule
